// File: rtl/alu_sequencer.sv
// Request/response front end for the 4-bit ALU: registers ALU inputs, waits a settle window,
// captures F/COUT into a response and an accumulator. Optional: ALU_SEQ_OPCNT_EN adds OP_CNT.
module alu_sequencer #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] ACC_RESET     = 4'h0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [3:0] REQ_OP,
  input  logic [3:0] REQ_A,
  input  logic [3:0] REQ_B,
  input  logic       REQ_CIN,
  input  logic       REQ_USE_ACC,
  output logic       ALU_SEL0,
  output logic       ALU_SEL1,
  output logic       ALU_SEL2,
  output logic       ALU_SEL3,
  output logic [3:0] ALU_A,
  output logic [3:0] ALU_B,
  output logic       ALU_CIN,
  input  logic [3:0] ALU_F,
  input  logic       ALU_COUT,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [3:0] RSP_F,
  output logic       RSP_COUT,
  output logic       RSP_ZERO,
  output logic [3:0] ACC,
  output logic [1:0] o_dbg_state
`ifdef ALU_SEQ_OPCNT_EN
  , output logic [7:0] OP_CNT
`endif
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready are both high;
  // valid and its payload stay stable until that edge, ready may depend combinationally on the sink.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_RESPOND = 2'd2} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_sel;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic       r_alu_cin;
  logic       r_rsp_valid;
  logic [3:0] r_rsp_f;
  logic       r_rsp_cout;
  logic       r_rsp_zero;
  logic [3:0] r_acc;
`ifdef ALU_SEQ_OPCNT_EN
  logic [7:0] r_op_cnt;
`endif

  logic w_req_ready;
  logic w_accept;

  assign w_req_ready = (r_state == S_IDLE) || ((r_state == S_RESPOND) && RSP_READY);
  assign w_accept    = REQ_VALID && w_req_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'h0;
      r_sel       <= 4'h0;
      r_alu_a     <= 4'h0;
      r_alu_b     <= 4'h0;
      r_alu_cin   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_f     <= 4'h0;
      r_rsp_cout  <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_acc       <= ACC_RESET;
`ifdef ALU_SEQ_OPCNT_EN
      r_op_cnt    <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_DRIVE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rsp_f     <= ALU_F;
            r_rsp_cout  <= ALU_COUT;
            r_rsp_zero  <= (ALU_F == 4'h0);
            r_acc       <= ALU_F;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
`ifdef ALU_SEQ_OPCNT_EN
            r_op_cnt    <= r_op_cnt + 8'd1;
`endif
          end
        end
        default: ;
      endcase
      // Accept overrides the RESPOND->IDLE move so back-to-back requests skip IDLE.
      if (w_accept) begin
        r_sel     <= REQ_OP;
        r_alu_a   <= REQ_USE_ACC ? r_acc : REQ_A;
        r_alu_b   <= REQ_B;
        r_alu_cin <= REQ_CIN;
        r_cnt     <= SETTLE_INIT;
        r_state   <= S_DRIVE;
      end
    end
  end

  assign REQ_READY   = w_req_ready;
  assign ALU_SEL0    = r_sel[0];
  assign ALU_SEL1    = r_sel[1];
  assign ALU_SEL2    = r_sel[2];
  assign ALU_SEL3    = r_sel[3];
  assign ALU_A       = r_alu_a;
  assign ALU_B       = r_alu_b;
  assign ALU_CIN     = r_alu_cin;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_F       = r_rsp_f;
  assign RSP_COUT    = r_rsp_cout;
  assign RSP_ZERO    = r_rsp_zero;
  assign ACC         = r_acc;
  assign o_dbg_state = r_state;
`ifdef ALU_SEQ_OPCNT_EN
  assign OP_CNT      = r_op_cnt;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + randomized bench for alu_sequencer; a behavioural ALU model closes the loop.
// A second instance with SETTLE_CYCLES=3 covers the longer settle window.
module tb_alu_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid = 1'b0, req3_valid = 1'b0;
  logic [3:0] req_op = 4'h0, req_a = 4'h0, req_b = 4'h0;
  logic       req_cin = 1'b0, req_use_acc = 1'b0;
  logic       rsp_ready = 1'b0;

  logic       req_ready, alu_sel0, alu_sel1, alu_sel2, alu_sel3, alu_cin, alu_cout;
  logic [3:0] alu_a, alu_b, alu_f, rsp_f, acc;
  logic       rsp_valid, rsp_cout, rsp_zero;
  logic [1:0] dbg_state;

  logic       req3_ready, s3_0, s3_1, s3_2, s3_3, alu3_cin, alu3_cout;
  logic [3:0] alu3_a, alu3_b, alu3_f, rsp3_f, acc3;
  logic       rsp3_valid, rsp3_cout, rsp3_zero;
  logic [1:0] dbg3_state;
`ifdef ALU_SEQ_OPCNT_EN
  logic [7:0] op_cnt, op_cnt3;
`endif

  int         chk_cnt = 0;
  int         err_cnt = 0;
  int         m_ops   = 0;
  logic [3:0] m_acc   = 4'h0;
  logic [3:0] exp_alu_a;
  logic [8:0] exp_q[$];

  always #5 CLK = ~CLK;

  // Bench ALU: ADD, SUB, AND, OR, XOR, NOT A; other selects pass B through.
  function automatic logic [4:0] alu_fn(input logic [3:0] op, a, b, input logic cin);
    case (op)
      4'b0000: alu_fn = {1'b0, a} + {1'b0, b} + {4'h0, cin};
      4'b0001: alu_fn = {1'b0, a} + {1'b0, ~b} + {4'h0, cin};
      4'b0100: alu_fn = {1'b0, a & b};
      4'b0101: alu_fn = {1'b0, a | b};
      4'b0110: alu_fn = {1'b0, a ^ b};
      4'b0111: alu_fn = {1'b0, ~a};
      default: alu_fn = {1'b0, b};
    endcase
  endfunction

  assign {alu_cout, alu_f}   = alu_fn({alu_sel3, alu_sel2, alu_sel1, alu_sel0}, alu_a, alu_b, alu_cin);
  assign {alu3_cout, alu3_f} = alu_fn({s3_3, s3_2, s3_1, s3_0}, alu3_a, alu3_b, alu3_cin);

  alu_sequencer #(.SETTLE_CYCLES(1), .ACC_RESET(4'h0)) u_dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_OP(req_op), .REQ_A(req_a), .REQ_B(req_b), .REQ_CIN(req_cin), .REQ_USE_ACC(req_use_acc),
    .ALU_SEL0(alu_sel0), .ALU_SEL1(alu_sel1), .ALU_SEL2(alu_sel2), .ALU_SEL3(alu_sel3),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_CIN(alu_cin), .ALU_F(alu_f), .ALU_COUT(alu_cout),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_F(rsp_f), .RSP_COUT(rsp_cout),
    .RSP_ZERO(rsp_zero), .ACC(acc), .o_dbg_state(dbg_state)
`ifdef ALU_SEQ_OPCNT_EN
    , .OP_CNT(op_cnt)
`endif
  );

  alu_sequencer #(.SETTLE_CYCLES(3), .ACC_RESET(4'h0)) u_dut3 (
    .CLK(CLK), .RST(RST), .REQ_VALID(req3_valid), .REQ_READY(req3_ready),
    .REQ_OP(req_op), .REQ_A(req_a), .REQ_B(req_b), .REQ_CIN(req_cin), .REQ_USE_ACC(req_use_acc),
    .ALU_SEL0(s3_0), .ALU_SEL1(s3_1), .ALU_SEL2(s3_2), .ALU_SEL3(s3_3),
    .ALU_A(alu3_a), .ALU_B(alu3_b), .ALU_CIN(alu3_cin), .ALU_F(alu3_f), .ALU_COUT(alu3_cout),
    .RSP_VALID(rsp3_valid), .RSP_READY(rsp_ready), .RSP_F(rsp3_f), .RSP_COUT(rsp3_cout),
    .RSP_ZERO(rsp3_zero), .ACC(acc3), .o_dbg_state(dbg3_state)
`ifdef ALU_SEQ_OPCNT_EN
    , .OP_CNT(op_cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives request fields and records the expected result for that request.
  task automatic prep(input logic [3:0] op, a, b, input logic cin, use_acc);
    logic [4:0] r;
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_use_acc = use_acc;
    exp_alu_a = use_acc ? m_acc : a;
    r = alu_fn(op, exp_alu_a, b, cin);
    exp_q.push_back({exp_alu_a, r});
    m_acc = r[3:0];
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic send(input logic [3:0] op, a, b, input logic cin, use_acc);
    prep(op, a, b, cin, use_acc);
    req_valid = 1'b1;
    chk("req_ready_idle", 16'(req_ready), 16'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("alu_sel", 16'({alu_sel3, alu_sel2, alu_sel1, alu_sel0}), 16'(op));
    chk("alu_a", 16'(alu_a), 16'(exp_alu_a));
    chk("alu_b", 16'(alu_b), 16'(b));
    chk("alu_cin", 16'(alu_cin), 16'(cin));
  endtask

  task automatic receive(input int hold, input bit handshake);
    int lat = 0;
    logic [8:0] e;
    while (!rsp_valid && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    chk("rsp_latency", 16'(lat), 16'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
    chk("rsp_f", 16'(rsp_f), 16'(e[3:0]));
    chk("rsp_cout", 16'(rsp_cout), 16'(e[4]));
    chk("rsp_zero", 16'(rsp_zero), 16'(e[3:0] == 4'h0));
    chk("acc", 16'(acc), 16'(e[3:0]));
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("rsp_hold_valid", 16'(rsp_valid), 16'd1);
      chk("rsp_hold_f", 16'(rsp_f), 16'(e[3:0]));
      chk("alu_a_hold", 16'(alu_a), 16'(e[8:5]));
    end
    if (handshake) begin
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      m_ops++;
      chk("rsp_valid_drop", 16'(rsp_valid), 16'd0);
      chk("state_idle", 16'(dbg_state), 16'd0);
    end
  endtask

  initial begin
    logic [3:0] prev_f, prev_a;
    int lat;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_alu", 16'({alu_sel3, alu_sel2, alu_sel1, alu_sel0, alu_a, alu_b, alu_cin}), 16'd0);
    chk("rst_rsp", 16'({rsp_f, rsp_cout, rsp_zero}), 16'd0);
    chk("rst_acc", 16'(acc), 16'h0);
    chk("rst_state", 16'(dbg_state), 16'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("req_ready_after_rst", 16'(req_ready), 16'd1);

    // AND 6 & 3 = 2
    send(4'b0100, 4'h6, 4'h3, 1'b0, 1'b0);
    receive(0, 1);

    // NOT 5 = A, then chain the accumulator into operand A
    send(4'b0111, 4'h5, 4'h0, 1'b0, 1'b0);
    receive(1, 1);
    send(4'b0000, 4'hF, 4'h1, 1'b0, 1'b1);
    chk("chain_alu_a", 16'(alu_a), 16'hA);
    receive(0, 1);

    // Response stall with a pending request, then back-to-back accept
    send(4'b0101, 4'h3, 4'h8, 1'b0, 1'b0);
    receive(0, 0);
    prev_f = m_acc;
    prev_a = exp_alu_a;
    prep(4'b0110, 4'h0, 4'h7, 1'b0, 1'b1);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_req_ready", 16'(req_ready), 16'd0);
      chk("stall_rsp_f", 16'(rsp_f), 16'(prev_f));
      chk("stall_alu_a", 16'(alu_a), 16'(prev_a));
      chk("stall_rsp_valid", 16'(rsp_valid), 16'd1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_req_ready", 16'(req_ready), 16'd1);
    @(negedge CLK);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    m_ops++;
    chk("b2b_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("b2b_state_drive", 16'(dbg_state), 16'd1);
    chk("b2b_alu_a", 16'(alu_a), 16'(exp_alu_a));
    receive(1, 1);

    // SETTLE_CYCLES=3: XOR 9^9 = 0
    req_op = 4'b0110; req_a = 4'h9; req_b = 4'h9; req_cin = 1'b0; req_use_acc = 1'b0;
    req3_valid = 1'b1;
    @(negedge CLK);
    req3_valid = 1'b0;
    lat = 0;
    while (!rsp3_valid && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    chk("settle3_latency", 16'(lat), 16'd3);
    chk("settle3_rsp_f", 16'(rsp3_f), 16'h0);
    chk("settle3_rsp_zero", 16'(rsp3_zero), 16'd1);
    chk("settle3_acc", 16'(acc3), 16'h0);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("settle3_rsp_drop", 16'(rsp3_valid), 16'd0);

    // Reset in the middle of DRIVE aborts the request
    send(4'b0101, 4'h5, 4'hA, 1'b1, 1'b0);
    chk("abort_in_drive", 16'(dbg_state), 16'd1);
    RST = 1'b1;
    #1;
    chk("abort_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("abort_alu", 16'({alu_sel3, alu_sel2, alu_sel1, alu_sel0, alu_a, alu_b, alu_cin}), 16'd0);
    chk("abort_acc", 16'(acc), 16'h0);
    #1;
    RST = 1'b0;
    void'(exp_q.pop_back());
    m_acc = 4'h0;
    m_ops = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("abort_no_rsp", 16'(rsp_valid), 16'd0);
      chk("abort_state", 16'(dbg_state), 16'd0);
    end
    send(4'b0000, 4'h7, 4'h9, 1'b1, 1'b0);
    receive(0, 1);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      receive($urandom_range(0, 3), 1'b1);
    end

`ifdef ALU_SEQ_OPCNT_EN
    while (m_ops < 257) begin
      send(4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      receive(0, 1'b1);
    end
    chk("op_cnt_wrap", 16'(op_cnt), 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Request/response front end for the 4-bit arithmetic_logic_unit. It accepts an operation request over a valid/ready handshake and drives the ALU select, operand and carry inputs from registers. It holds those inputs for a settle window, captures F/COUT and returns them over a second valid/ready handshake. An internal accumulator holds the last result and can replace operand A, which allows chained micro-operation sequences.

Parameters:
SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture; legal range 1..15.
ACC_RESET, 4'h0, accumulator value after reset.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
REQ_VALID  in  1  request present
REQ_READY  out  1  request accepted this cycle when high with REQ_VALID
REQ_OP  in  4  {SEL3,SEL2,SEL1,SEL0} for the ALU
REQ_A  in  4  operand A
REQ_B  in  4  operand B
REQ_CIN  in  1  carry-in
REQ_USE_ACC  in  1  1 = use the accumulator as operand A instead of REQ_A
ALU_SEL0..ALU_SEL3  out  1 each  registered ALU select lines
ALU_A, ALU_B  out  4  registered ALU operands
ALU_CIN  out  1  registered ALU carry-in
ALU_F  in  4  ALU result
ALU_COUT  in  1  ALU carry-out
RSP_VALID  out  1  response present
RSP_READY  in  1  consumer accepts response
RSP_F  out  4  captured result
RSP_COUT  out  1  captured carry-out
RSP_ZERO  out  1  1 when captured result is 4'h0
ACC  out  4  accumulator value

Behaviour:
- FSM states: IDLE, DRIVE, RESPOND. Reset state is IDLE.
- Reset values:
  - ALU_SEL0..3, ALU_A, ALU_B, ALU_CIN, RSP_F, RSP_COUT and RSP_VALID are 0.
  - RSP_ZERO is 0.
  - ACC is ACC_RESET.
  - The internal settle counter is 0.
- REQ_READY is combinational: high in IDLE, or in RESPOND when RSP_READY=1. It is low in DRIVE.
- Accept happens on a clock edge where REQ_VALID and REQ_READY are both high. On accept:
  - ALU_SEL3..0 <= REQ_OP[3:0].
  - ALU_A <= REQ_USE_ACC ? ACC : REQ_A, using the ACC value before this edge.
  - ALU_B <= REQ_B and ALU_CIN <= REQ_CIN.
  - Settle counter <= SETTLE_CYCLES; next state is DRIVE.
- DRIVE: the counter decrements each edge. On the edge where the counter is 1:
  - RSP_F <= ALU_F, RSP_COUT <= ALU_COUT, RSP_ZERO <= (ALU_F==0).
  - ACC <= ALU_F and RSP_VALID <= 1; next state is RESPOND.
- Latency: RSP_VALID rises SETTLE_CYCLES edges after the accept edge.
- RESPOND:
  - RSP_VALID and RSP_* stay stable until an edge with RSP_READY=1.
  - On that edge, RSP_VALID <= 0. The FSM goes to DRIVE if a new request is accepted on the same edge (back-to-back), otherwise to IDLE.
- ALU_* outputs hold their values from accept until the next accept. They do not change in IDLE or RESPOND.
- Request fields are sampled only at accept. Changes while REQ_READY is low are ignored.
- Reset asserted mid-operation aborts the in-flight request: there is no response, all registers return to reset values and the FSM goes to IDLE. Deassertion is synchronised by the system.
- The ALU is purely combinational; the block captures no state from it outside the capture edge.

Optional Feature:
ALU_SEQ_OPCNT_EN: when defined, an extra output OP_CNT [7:0] counts completed response handshakes. It resets to 0 and wraps from 255 to 0. When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then a request with REQ_OP=4'b0100, A=4'h6, B=4'h3, CIN=0 and SETTLE_CYCLES=1, against a bench AND model -> ALU_SEL={0,1,0,0}; one edge later RSP_VALID=1, RSP_F=4'h2, RSP_ZERO=0, ACC=4'h2.
2. Request with REQ_OP=4'b0111, A=4'h5, against a NOT model (F=~A) -> RSP_F=4'hA. A follow-up with REQ_USE_ACC=1 and REQ_A=4'hF drives ALU_A=4'hA.
3. RSP_READY held low 5 cycles while REQ_VALID=1 -> REQ_READY=0, RSP_F stable and ALU_* unchanged. The edge with RSP_READY=1 accepts the next request back-to-back, with no IDLE cycle.
4. SETTLE_CYCLES=3 and an XOR op with A=4'h9, B=4'h9 -> RSP_VALID rises exactly 3 edges after accept, RSP_F=4'h0, RSP_ZERO=1.
5. RST pulsed during DRIVE -> no response is issued, all outputs return to 0, ACC=ACC_RESET, and a fresh request completes normally.
6. With ALU_SEQ_OPCNT_EN defined, 257 completed transactions -> OP_CNT=1.
